// File: rtl/axi_lite_arbiter_pkg.sv
// Shared bus package for the AXI-Lite arbiter slice.
// Holds the bus widths, the master-index type and the arbiter FSM state
// encoding. The axi_lite_if interface (rtl/axi_lite_if.sv) imports it.
package axi_lite_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Index of an upstream master (0 = IFU, 1 = LSU).
  typedef logic mst_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } arb_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus interface (aw, w, b, ar, r channels).
// Modports:
//   master - the side that issues requests (drives valids/addr/data, bready, rready)
//   slave  - the side that answers (drives readies, b and r channels)
interface axi_lite_if;
  import axi_lite_arbiter_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_arbiter_rr.sv
// Two-way round-robin arbiter (combinational).
// Ports:
//   req[1:0]   - request per master
//   last_grant - master granted most recently
//   grant      - winning master; on a tie the one that did not win last time,
//                a lone requester always wins. Meaningless when req == 0.
module rr_arbiter2
  import axi_lite_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_grant,
  output mst_idx_t   grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter, one transaction at a time.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   m0      - upstream master 0 (IFU), wins the first tie after reset
//   m1      - upstream master 1 (LSU)
//   s       - shared downstream slave
// A grant is taken in IDLE (one bubble cycle) and held until the r or b
// handshake closes the transaction.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  axi_lite_if.slave   m0,
  axi_lite_if.slave   m1,
  axi_lite_if.master  s
);

  arb_state_t state_q, state_d;
  mst_idx_t   grant_q, grant_d;
  mst_idx_t   last_grant_q, last_grant_d;
  mst_idx_t   arb_grant;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] req;
  logic       arb_wr_pend;
  logic       aw_fire, w_fire;

  // Granted-master request signals
  logic g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  // Handshake signals returned to the granted master
  logic g_arready, g_rvalid, g_awready, g_wready, g_bvalid;
  // Handshake signals driven to the slave
  logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

  assign req[0] = m0.arvalid | m0.awvalid | m0.wvalid;
  assign req[1] = m1.arvalid | m1.awvalid | m1.wvalid;

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  // Write beats outrank reads within the master that wins arbitration.
  assign arb_wr_pend = arb_grant ? (m1.awvalid | m1.wvalid) : (m0.awvalid | m0.wvalid);

  assign g_arvalid = grant_q ? m1.arvalid : m0.arvalid;
  assign g_rready  = grant_q ? m1.rready  : m0.rready;
  assign g_awvalid = grant_q ? m1.awvalid : m0.awvalid;
  assign g_wvalid  = grant_q ? m1.wvalid  : m0.wvalid;
  assign g_bready  = grant_q ? m1.bready  : m0.bready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    aw_fire      = 1'b0;
    w_fire       = 1'b0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    s_awvalid    = 1'b0;
    s_wvalid     = 1'b0;
    s_bready     = 1'b0;
    g_arready    = 1'b0;
    g_rvalid     = 1'b0;
    g_awready    = 1'b0;
    g_wready     = 1'b0;
    g_bvalid     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          state_d      = arb_wr_pend ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        s_arvalid = g_arvalid;
        g_arready = s.arready;
        if (s_arvalid && s.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        g_rvalid = s.rvalid;
        s_rready = g_rready;
        if (s.rvalid && s_rready) state_d = IDLE;
      end
      WR_REQ: begin
        // aw and w complete independently; a finished channel is masked
        // so the master cannot push a second beat on it.
        s_awvalid = g_awvalid & ~aw_done_q;
        g_awready = s.awready & ~aw_done_q;
        s_wvalid  = g_wvalid & ~w_done_q;
        g_wready  = s.wready & ~w_done_q;
        aw_fire   = s_awvalid & s.awready;
        w_fire    = s_wvalid & s.wready;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RESP;
      end
      WR_RESP: begin
        g_bvalid = s.bvalid;
        s_bready = g_bready;
        if (s.bvalid && s_bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream: address/data follow the granted master, handshakes gated by state.
  assign s.araddr  = grant_q ? m1.araddr : m0.araddr;
  assign s.awaddr  = grant_q ? m1.awaddr : m0.awaddr;
  assign s.wdata   = grant_q ? m1.wdata  : m0.wdata;
  assign s.arvalid = s_arvalid;
  assign s.rready  = s_rready;
  assign s.awvalid = s_awvalid;
  assign s.wvalid  = s_wvalid;
  assign s.bready  = s_bready;

  // Upstream: only the granted master sees handshakes; payloads pass through.
  assign m0.arready = ~grant_q & g_arready;
  assign m0.rvalid  = ~grant_q & g_rvalid;
  assign m0.awready = ~grant_q & g_awready;
  assign m0.wready  = ~grant_q & g_wready;
  assign m0.bvalid  = ~grant_q & g_bvalid;
  assign m0.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;
  assign m0.bresp   = s.bresp;

  assign m1.arready = grant_q & g_arready;
  assign m1.rvalid  = grant_q & g_rvalid;
  assign m1.awready = grant_q & g_awready;
  assign m1.wready  = grant_q & g_wready;
  assign m1.bvalid  = grant_q & g_bvalid;
  assign m1.rdata   = s.rdata;
  assign m1.rresp   = s.rresp;
  assign m1.bresp   = s.bresp;

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 The block SHALL have no parameters; each master port carries exactly one outstanding transaction at a time.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- m0  axi_lite_if.slave  interface  master 0 (IFU); higher priority after reset.
- m1  axi_lite_if.slave  interface  master 1 (LSU).
- s  axi_lite_if.master  interface  shared downstream slave (UART/memory bus).

Function
REQ-003 The request from master i SHALL be mi.arvalid | mi.awvalid | mi.wvalid.
REQ-004 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WR_REQ and WR_RESP, and grant SHALL be a registered 1-bit index.
REQ-005 In IDLE with any request, the block SHALL grant round-robin: the master not equal to last_grant wins on a tie, and a lone requester always wins.
REQ-006 Grant, last_grant and the next state SHALL register on the same edge, giving a 1-cycle arbitration bubble; no channel is forwarded while in IDLE.
REQ-007 Within the granted master, a pending write (awvalid|wvalid) SHALL take precedence over arvalid: IDLE->WR_REQ, otherwise IDLE->RD_ADDR.
REQ-008 In RD_ADDR, the ar channel of the granted master SHALL be forwarded to s (araddr, arvalid, arready back); on s.arvalid&s.arready the FSM SHALL go to RD_DATA.
REQ-009 In RD_DATA, r SHALL be forwarded (rdata, rresp, rvalid to the master, rready to s); on rvalid&rready the FSM SHALL go to IDLE.
REQ-010 In WR_REQ, aw and w SHALL be forwarded independently with aw_done/w_done flags; a channel whose flag is set SHALL drive valid=0 to s and ready=0 to the master.
REQ-011 WR_REQ SHALL go to WR_RESP once both handshakes have completed, whether in the same cycle or in different cycles in either order.
REQ-012 In WR_RESP, b SHALL be forwarded; on bvalid&bready the FSM SHALL clear aw_done/w_done and go to IDLE.
REQ-013 The non-granted master, and every master while in IDLE, SHALL see arready, awready, wready, rvalid and bvalid at 0.
REQ-014 Outputs to s outside the active channel SHALL be valid=0 and ready=0, with addr/data don't-care but driven with the granted master's values.
REQ-015 rresp and bresp SHALL pass through unmodified; SLVERR is not generated locally.
REQ-016 The grant SHALL stay locked until the response handshake completes; backpressure of any length SHALL NOT re-arbitrate.
REQ-017 A master deasserting valid before its handshake is an AXI violation; the block SHALL NOT recover from it, and the bench flags it via assertion.

Reset
REQ-018 On reset_n=0, asynchronously: state=IDLE, grant=0, last_grant=1 (so m0 wins first), aw_done=w_done=0.
REQ-019 During reset, all valid/ready outputs on m0, m1 and s SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abandon that transaction without completing it; after release, arbitration restarts from REQ-018 values.

Structure
REQ-021 The FSM state enum (arb_state_t) and the master-index type SHALL live in the shared bus package alongside the axi_lite_if definitions.
REQ-022 A sub-module rr_arbiter2 (req[1:0], last_grant -> grant) is natural; the rest SHALL be a single module.

Verification
REQ-023 After reset, m0 alone writes awaddr=0xa00003f8, wdata=0x41 in the same cycle -> s sees one aw+w handshake, m0 gets bresp=00, and m1 ready/valid stay 0 throughout.
REQ-024 m0 read at 0x80000000 and m1 write at 0xa00003f8 raised in the same cycle after reset -> m0 granted first; m1 aw is forwarded only after m0 r handshake and one IDLE cycle.
REQ-025 Both masters issue continuous reads for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-026 The granted master presents wvalid 2 cycles before awvalid -> w forwarded first, aw later, exactly one b forwarded, and WR_RESP entered only after both handshakes.
REQ-027 The slave holds rvalid=1 with the master's rready=0 for 3 cycles while the other master requests -> grant unchanged; rdata=0xdeadbeef is delivered on the 4th cycle.
REQ-028 reset_n pulsed low in WR_RESP -> all valids drop in the same cycle, and the next request after release is served with m0 priority.
